// File: rtl/axis_burst_framer.sv
// Groups an AXI-Stream word flow into fixed-length bursts marked with tlast.
// A partial burst is closed after a configurable number of idle input cycles.
module axis_burst_framer #(
  parameter int WIDTH    = 32,
  parameter int LEN_BITS = 12,
  parameter int TMO_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEN_BITS-1:0] cfg_burst_len,
  input  logic [TMO_BITS-1:0] cfg_timeout,
  input  logic [WIDTH-1:0]    s_rx_tdata,
  input  logic                s_rx_tvalid,
  output logic                s_rx_tready,
  output logic [WIDTH-1:0]    m_tx_tdata,
  output logic                m_tx_tvalid,
  input  logic                m_tx_tready,
  output logic                m_tx_tlast,
  output logic [15:0]         stat_bursts,
  output logic [15:0]         stat_short
);

  logic                h_valid_q, h_valid_d;
  logic                h_last_q,  h_last_d;
  logic [WIDTH-1:0]    h_data_q,  h_data_d;
  logic                o_valid_q, o_valid_d;
  logic                o_last_q,  o_last_d;
  logic [WIDTH-1:0]    o_data_q,  o_data_d;
  logic [LEN_BITS-1:0] idx_q,     idx_d;
  logic [LEN_BITS-1:0] len_q,     len_d;
  logic [TMO_BITS-1:0] tmo_q,     tmo_d;
  logic [15:0]         bursts_q,  bursts_d;
  logic [15:0]         short_q,   short_d;

  logic                accept;
  logic                o_free;
  logic                h_to_o;
  logic [LEN_BITS-1:0] len_eff;
  logic                word_final;
  logic                tmo_run;
  logic [TMO_BITS-1:0] tmo_inc;
  logic                expire;
  logic                out_last_beat;

  // H can always accept when it will move into O this cycle, so ready
  // only drops while both stages are full and the output is stalled.
  assign s_rx_tready = !h_valid_q || !o_valid_q || m_tx_tready;

  always_comb begin
    accept        = s_rx_tvalid && s_rx_tready;
    o_free        = !o_valid_q || m_tx_tready;
    h_to_o        = h_valid_q && o_free && (h_last_q || accept);
    // The first word of a burst compares against the live config, which is
    // also what gets latched for the rest of the burst.
    len_eff       = (idx_q == '0) ? cfg_burst_len : len_q;
    word_final    = (idx_q == len_eff);
    tmo_run       = h_valid_q && !h_last_q && !accept;
    tmo_inc       = tmo_q + 1'b1;
    expire        = tmo_run && (cfg_timeout != '0) && (tmo_inc == cfg_timeout);
    out_last_beat = o_valid_q && m_tx_tready && o_last_q;
  end

  always_comb begin
    h_valid_d = h_valid_q;
    h_last_d  = h_last_q;
    h_data_d  = h_data_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_data_d  = o_data_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tmo_d     = '0;
    bursts_d  = bursts_q;
    short_d   = short_q;

    if (h_to_o) begin
      o_valid_d = 1'b1;
      o_last_d  = h_last_q;
      o_data_d  = h_data_q;
    end else if (o_free) begin
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end

    if (accept) begin
      h_valid_d = 1'b1;
      h_data_d  = s_rx_tdata;
      h_last_d  = word_final;
      idx_d     = word_final ? '0 : idx_q + 1'b1;
      if (idx_q == '0) begin
        len_d = cfg_burst_len;
      end
    end else if (h_to_o) begin
      h_valid_d = 1'b0;
      h_last_d  = 1'b0;
    end else if (expire) begin
      h_last_d = 1'b1;
      idx_d    = '0;
      short_d  = short_q + 1'b1;
    end

    if (tmo_run && !expire) begin
      tmo_d = tmo_inc;
    end

    if (out_last_beat) begin
      bursts_d = bursts_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid_q <= 1'b0;
      h_last_q  <= 1'b0;
      h_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      tmo_q     <= '0;
      bursts_q  <= '0;
      short_q   <= '0;
    end else begin
      h_valid_q <= h_valid_d;
      h_last_q  <= h_last_d;
      h_data_q  <= h_data_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_data_q  <= o_data_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      bursts_q  <= bursts_d;
      short_q   <= short_d;
    end
  end

  assign m_tx_tdata  = o_data_q;
  assign m_tx_tvalid = o_valid_q;
  assign m_tx_tlast  = o_last_q;
  assign stat_bursts = bursts_q;
  assign stat_short  = short_q;

endmodule

// File: tb/tb_axis_burst_framer.sv
// Directed bench for axis_burst_framer: burst framing, idle timeout,
// backpressure, reset mid-burst and statistics wrap.
module tb_axis_burst_framer;
  localparam int W  = 32;
  localparam int LB = 12;
  localparam int TB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LB-1:0] cfg_burst_len = '0;
  logic [TB-1:0] cfg_timeout = '0;
  logic [W-1:0]  s_rx_tdata = '0;
  logic          s_rx_tvalid = 1'b0;
  logic          s_rx_tready;
  logic [W-1:0]  m_tx_tdata;
  logic          m_tx_tvalid;
  logic          m_tx_tready = 1'b1;
  logic          m_tx_tlast;
  logic [15:0]   stat_bursts;
  logic [15:0]   stat_short;

  axis_burst_framer #(.WIDTH(W), .LEN_BITS(LB), .TMO_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_burst_len(cfg_burst_len), .cfg_timeout(cfg_timeout),
    .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid), .s_rx_tready(s_rx_tready),
    .m_tx_tdata(m_tx_tdata), .m_tx_tvalid(m_tx_tvalid), .m_tx_tready(m_tx_tready),
    .m_tx_tlast(m_tx_tlast), .stat_bursts(stat_bursts), .stat_short(stat_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    int           c;
  } beat_t;

  beat_t        q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           stall_err = 0;
  bit           mon_rec = 1'b1;
  bit           rand_en = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_d;
  logic         prev_l;

  // cyc equals the index of the current clock cycle between edges.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) m_tx_tready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: records every beat and flags any change while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall && (!m_tx_tvalid || m_tx_tdata !== prev_d || m_tx_tlast !== prev_l))
          stall_err++;
        if (mon_rec && m_tx_tvalid && m_tx_tready) q.push_back('{m_tx_tdata, m_tx_tlast, cyc});
        prev_stall = m_tx_tvalid && !m_tx_tready;
        prev_d = m_tx_tdata;
        prev_l = m_tx_tlast;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one word; acc returns the cycle in which it was accepted.
  task automatic send(input logic [W-1:0] d, output int acc, output bit ok);
    bit rdy;
    ok = 1'b0;
    s_rx_tvalid = 1'b1;
    s_rx_tdata = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      rdy = s_rx_tready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
    end
    s_rx_tvalid = 1'b0;
    acc = cyc - 1;
  endtask

  task automatic idle(input int n);
    s_rx_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input int bound);
    for (int k = 0; k < bound && q.size() < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    s_rx_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    #2;
    total++; if (m_tx_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", m_tx_tvalid); end
    total++; if (m_tx_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b want=0", m_tx_tlast); end
    total++; if (stat_bursts !== 16'd0) begin bad++; $display("FAIL rst_bursts got=%0d want=0", stat_bursts); end
    total++; if (stat_short !== 16'd0) begin bad++; $display("FAIL rst_short got=%0d want=0", stat_short); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++; if (s_rx_tready !== 1'b1) begin bad++; $display("FAIL rst_tready got=%b want=1", s_rx_tready); end
    $display("test_reset done");
  endtask

  task automatic test_continuous();
    int acc, n0, nbad;
    bit ok;
    do_reset();
    cfg_burst_len = 12'd3;
    cfg_timeout = '0;
    m_tx_tready = 1'b1;
    nbad = 0;
    n0 = 0;
    for (int i = 0; i < 12; i++) begin
      send(W'(i), acc, ok);
      if (!ok) nbad++;
      if (i == 0) n0 = acc;
    end
    drain(12, 50);
    total++; if (nbad != 0) begin bad++; $display("FAIL cont_accept got=%0d want=0 rejected", nbad); end
    total++; if (q.size() != 12) begin bad++; $display("FAIL cont_count got=%0d want=12", q.size()); end
    for (int i = 0; i < 12 && i < q.size(); i++) begin
      total++;
      if (q[i].d !== W'(i) || q[i].l !== (i % 4 == 3)) begin
        bad++; $display("FAIL cont_beat%0d got=%0h/%b want=%0h/%b", i, q[i].d, q[i].l, i, (i % 4 == 3));
      end
    end
    if (q.size() > 0) begin
      total++; if (q[0].c != n0 + 2) begin bad++; $display("FAIL cont_latency got=%0d want=%0d", q[0].c - n0, 2); end
    end
    total++; if (stat_bursts !== 16'd3) begin bad++; $display("FAIL cont_bursts got=%0d want=3", stat_bursts); end
    $display("test_continuous done beats=%0d", q.size());
  endtask

  task automatic test_timeout();
    int acc, n1, nbad;
    bit ok;
    do_reset();
    cfg_burst_len = 12'd3;
    cfg_timeout = 16'd5;
    m_tx_tready = 1'b1;
    nbad = 0;
    send(32'hA0, acc, ok); if (!ok) nbad++;
    send(32'hA1, n1, ok);  if (!ok) nbad++;
    drain(2, 40);
    total++; if (q.size() != 2) begin bad++; $display("FAIL tmo_count got=%0d want=2", q.size()); end
    if (q.size() >= 2) begin
      total++; if (q[0].d !== 32'hA0 || q[0].l !== 1'b0) begin bad++; $display("FAIL tmo_w0 got=%0h/%b want=a0/0", q[0].d, q[0].l); end
      total++; if (q[1].d !== 32'hA1 || q[1].l !== 1'b1) begin bad++; $display("FAIL tmo_w1 got=%0h/%b want=a1/1", q[1].d, q[1].l); end
      // five idle cycles close H, one cycle moves it into O, then it is presented
      total++; if (q[1].c != n1 + 7) begin bad++; $display("FAIL tmo_time got=%0d want=%0d", q[1].c - n1, 7); end
    end
    total++; if (stat_short !== 16'd1) begin bad++; $display("FAIL tmo_short got=%0d want=1", stat_short); end
    for (int i = 0; i < 4; i++) begin
      send(32'hB0 + W'(i), acc, ok);
      if (!ok) nbad++;
    end
    drain(6, 40);
    total++; if (nbad != 0) begin bad++; $display("FAIL tmo_accept got=%0d want=0 rejected", nbad); end
    total++; if (q.size() != 6) begin bad++; $display("FAIL tmo_count2 got=%0d want=6", q.size()); end
    for (int i = 2; i < 6 && i < q.size(); i++) begin
      total++;
      if (q[i].d !== 32'hB0 + W'(i - 2) || q[i].l !== (i == 5)) begin
        bad++; $display("FAIL tmo_next%0d got=%0h/%b want=%0h/%b", i - 2, q[i].d, q[i].l, 32'hB0 + i - 2, (i == 5));
      end
    end
    total++; if (stat_short !== 16'd1) begin bad++; $display("FAIL tmo_short2 got=%0d want=1", stat_short); end
    total++; if (stat_bursts !== 16'd2) begin bad++; $display("FAIL tmo_bursts got=%0d want=2", stat_bursts); end
    $display("test_timeout done beats=%0d", q.size());
  endtask

  task automatic test_backpressure();
    int acc, nbad;
    bit ok;
    do_reset();
    cfg_burst_len = 12'd1;
    cfg_timeout = '0;
    stall_err = 0;
    nbad = 0;
    rand_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(32'hC00 + W'(i), acc, ok);
      if (!ok) nbad++;
    end
    drain(16, 400);
    rand_en = 1'b0;
    #1;
    m_tx_tready = 1'b1;
    idle(2);
    total++; if (nbad != 0) begin bad++; $display("FAIL bp_accept got=%0d want=0 rejected", nbad); end
    total++; if (q.size() != 16) begin bad++; $display("FAIL bp_count got=%0d want=16", q.size()); end
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      total++;
      if (q[i].d !== 32'hC00 + W'(i) || q[i].l !== (i % 2 == 1)) begin
        bad++; $display("FAIL bp_beat%0d got=%0h/%b want=%0h/%b", i, q[i].d, q[i].l, 32'hC00 + i, (i % 2 == 1));
      end
    end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0 changes", stall_err); end
    total++; if (stat_bursts !== 16'd8) begin bad++; $display("FAIL bp_bursts got=%0d want=8", stat_bursts); end
    $display("test_backpressure done beats=%0d", q.size());
  endtask

  task automatic test_expiry_race();
    int acc, nbad;
    bit ok;
    do_reset();
    cfg_burst_len = 12'd3;
    cfg_timeout = 16'd4;
    m_tx_tready = 1'b1;
    nbad = 0;
    send(32'hD0, acc, ok); if (!ok) nbad++;
    idle(3);
    for (int i = 1; i < 4; i++) begin
      send(32'hD0 + W'(i), acc, ok);
      if (!ok) nbad++;
    end
    drain(4, 40);
    total++; if (nbad != 0) begin bad++; $display("FAIL race_accept got=%0d want=0 rejected", nbad); end
    total++; if (q.size() != 4) begin bad++; $display("FAIL race_count got=%0d want=4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      total++;
      if (q[i].d !== 32'hD0 + W'(i) || q[i].l !== (i == 3)) begin
        bad++; $display("FAIL race_beat%0d got=%0h/%b want=%0h/%b", i, q[i].d, q[i].l, 32'hD0 + i, (i == 3));
      end
    end
    total++; if (stat_short !== 16'd0) begin bad++; $display("FAIL race_short got=%0d want=0", stat_short); end
    $display("test_expiry_race done beats=%0d", q.size());
  endtask

  task automatic test_reset_mid();
    int acc, nbad;
    bit ok;
    q.delete();
    cfg_burst_len = 12'd3;
    cfg_timeout = '0;
    m_tx_tready = 1'b0;
    nbad = 0;
    send(32'hE0, acc, ok); if (!ok) nbad++;
    send(32'hE1, acc, ok); if (!ok) nbad++;
    idle(2);
    @(negedge clk);
    total++; if (m_tx_tvalid !== 1'b1) begin bad++; $display("FAIL mid_stalled got=%b want=1", m_tx_tvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (m_tx_tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got=%b want=0", m_tx_tvalid); end
    total++; if (stat_bursts !== 16'd0 || stat_short !== 16'd0) begin
      bad++; $display("FAIL mid_stats got=%0d/%0d want=0/0", stat_bursts, stat_short);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_tx_tready = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      send(32'hF0 + W'(i), acc, ok);
      if (!ok) nbad++;
    end
    drain(4, 40);
    idle(2);
    total++; if (nbad != 0) begin bad++; $display("FAIL mid_accept got=%0d want=0 rejected", nbad); end
    total++; if (q.size() != 4) begin bad++; $display("FAIL mid_count got=%0d want=4", q.size()); end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      total++;
      if (q[i].d !== 32'hF0 + W'(i) || q[i].l !== (i == 3)) begin
        bad++; $display("FAIL mid_beat%0d got=%0h/%b want=%0h/%b", i, q[i].d, q[i].l, 32'hF0 + i, (i == 3));
      end
    end
    total++; if (stat_bursts !== 16'd1) begin bad++; $display("FAIL mid_bursts got=%0d want=1", stat_bursts); end
    $display("test_reset_mid done beats=%0d", q.size());
  endtask

  task automatic test_wrap();
    int acc, nbad;
    bit ok;
    do_reset();
    cfg_burst_len = '0;
    cfg_timeout = '0;
    m_tx_tready = 1'b1;
    mon_rec = 1'b0;
    nbad = 0;
    for (int i = 0; i < 65537; i++) begin
      send(W'(i), acc, ok);
      if (!ok) nbad++;
    end
    idle(4);
    mon_rec = 1'b1;
    total++; if (nbad != 0) begin bad++; $display("FAIL wrap_accept got=%0d want=0 rejected", nbad); end
    total++; if (stat_bursts !== 16'd1) begin bad++; $display("FAIL wrap_bursts got=%0d want=1", stat_bursts); end
    total++; if (stat_short !== 16'd0) begin bad++; $display("FAIL wrap_short got=%0d want=0", stat_short); end
    $display("test_wrap done bursts=%0d", stat_bursts);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_timeout();
    test_backpressure();
    test_expiry_race();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_burst_framer.md
AXIS_BURST_FRAMER -- requirements
Module: axis_burst_framer

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, as the data width in bits.
REQ-002 The block SHALL expose parameter LEN_BITS, default 12, as the width of the burst-length config.
REQ-003 The block SHALL expose parameter TMO_BITS, default 16, as the width of the idle-timeout config.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
REQ-005 Config ports SHALL be:
- cfg_burst_len  in  LEN_BITS  words per burst minus 1
- cfg_timeout  in  TMO_BITS  idle cycles before a partial burst closes; 0 disables
REQ-006 The upstream AXIS slave (fed by the clock-crossing FIFO) SHALL be:
- s_rx_tdata  in  WIDTH
- s_rx_tvalid  in  1
- s_rx_tready  out  1
REQ-007 The downstream AXIS master SHALL be:
- m_tx_tdata  out  WIDTH
- m_tx_tvalid  out  1
- m_tx_tready  in  1
- m_tx_tlast  out  1  burst end
REQ-008 Status ports SHALL be:
- stat_bursts  out  16  completed bursts, wrapping
- stat_short  out  16  timeout-closed bursts, wrapping

Function
REQ-009 Datapath SHALL be two registers: hold H (h_valid, h_last, data), then output O (o_valid, o_last, data); O drives m_tx_*.
REQ-010 Burst index idx (LEN_BITS) SHALL count words loaded into H. cfg_burst_len is latched into len_q when idx==0 on accept; cfg changes mid-burst have no effect.
REQ-011 A word accepted with idx==len_q SHALL load H with h_last=1 and reset idx to 0; otherwise h_last=0 and idx increments.
REQ-012 s_rx_tready SHALL be !h_valid || !o_valid || m_tx_tready (combinational from m_tx_tready is permitted).
REQ-013 O is free when !o_valid || m_tx_tready.
REQ-014 H->O transfer SHALL occur when h_valid, O is free, and either h_last==1 or an input word is accepted in the same cycle; O takes H's data and h_last.
REQ-015 Input accept with h_valid=1 and h_last=0 SHALL always coincide with a H->O transfer with o_last=0.
REQ-016 If O becomes free with no transfer, o_valid SHALL clear on the consuming beat.
REQ-017 Latency SHALL be as follows:
- A final word (idx==len_q) accepted in cycle N SHALL present at m_tx in N+2 with an unstalled output.
- A non-final word SHALL wait in H for the next input or for timeout.
REQ-018 Timeout counter tmo (TMO_BITS) SHALL reset to 0 on any input accept or when H is empty/last, and increment each cycle while h_valid && !h_last && no accept.
REQ-019 When tmo reaches cfg_timeout (nonzero), the block SHALL set h_last=1, reset idx to 0, and pulse the short-burst event; H then drains per REQ-014.
REQ-020 For simultaneous timeout expiry and input accept, the accept SHALL win: no short burst, and tmo resets.
REQ-021 cfg_timeout==0 SHALL never close a burst by timeout.
REQ-022 stat_bursts SHALL increment on each m_tx beat with tlast (tvalid&&tready&&tlast); stat_short SHALL increment once per REQ-019 event.
REQ-023 Both stat counters SHALL wrap 0xFFFF->0.
REQ-024 m_tx_tdata/m_tx_tlast SHALL hold stable while m_tx_tvalid && !m_tx_tready.

Reset
REQ-025 With rst_n low, asynchronously and immediately: h_valid=0, o_valid=0, m_tx_tvalid=0, m_tx_tlast=0, s_rx_tready=1 after deassert, idx=0, tmo=0, len_q=0, stat_bursts=0, stat_short=0.
REQ-026 Reset mid-burst SHALL discard H and O contents; the first word after reset starts a new burst at idx 0.
REQ-027 Release SHALL be synchronous to clk (externally synchronized deassertion).

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- len=3, timeout=0, continuous input 0..11, tready=1 -> 12 beats, tlast on words 3,7,11, stat_bursts=3, first tvalid 2 cycles after first accept.
- len=3, timeout=5, send 2 words then idle -> word1 out with tlast 5 idle cycles later (+1 drain), stat_short=1; next word starts new burst.
- len=1, m_tx_tready random 50% -> no drops, duplicates, or data change during stall; tlast on every 2nd word.
- timeout=4, input word arrives exactly on expiry cycle -> no tlast on held word, stat_short unchanged.
- Assert rst_n low mid-burst with O stalled -> m_tx_tvalid drops immediately, all stats 0, next burst counts from idx 0.
- Run 65537 bursts of len=0 -> stat_bursts wraps to 1.
